rr_select_mux_pipe: RTL

//  Parametrised, registered N-to-1 word selector with valid/ready handshakes on

---
 rtl/rr_select_mux_pipe.sv | 102 ++++++++++
 1 files changed

// File: rtl/rr_select_mux_pipe.sv
// Registered N-to-1 word selector with valid/ready handshakes on every input and the output.
// Mode 0 picks the channel named by i_sel; mode 1 arbitrates round-robin among requesters.
module rr_select_mux_pipe #(
    parameter int RV_BIT_NUM = 32,
    parameter int NUM_IN     = 5,
    parameter int SEL_W      = $clog2(NUM_IN)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_mode,
    input  logic [SEL_W-1:0]             i_sel,
    input  logic [NUM_IN-1:0]            i_in_valid,
    input  logic [NUM_IN*RV_BIT_NUM-1:0] i_in_data,
    output logic [NUM_IN-1:0]            o_in_ready,
    output logic                         o_out_valid,
    output logic [RV_BIT_NUM-1:0]        o_out_data,
    output logic [SEL_W-1:0]             o_out_src,
    input  logic                         i_out_ready,
    output logic                         o_sel_err
);
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W:0] LAST_W   = (SEL_W+1)'(NUM_IN - 1);

    logic                  r_out_valid;
    logic [RV_BIT_NUM-1:0] r_out_data;
    logic [SEL_W-1:0]      r_out_src;
    logic [SEL_W-1:0]      r_ptr;
    logic                  r_sel_err;

    logic                  w_load_en;
    logic                  w_sel_ok;
    logic                  w_grant_vld;
    logic [SEL_W-1:0]      w_grant;
    logic [SEL_W-1:0]      w_ptr_next;
    logic [RV_BIT_NUM-1:0] w_data;
    logic                  w_xfer;

    assign w_load_en = !r_out_valid || i_out_ready;
    assign w_sel_ok  = {1'b0, i_sel} < NUM_IN_W;

    // Round-robin scan starts at r_ptr and wraps; the first requester found wins.
    always_comb begin : grant_logic
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        if (!i_mode) begin
            w_grant_vld = w_sel_ok;
            w_grant     = i_sel;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                idx = int'(r_ptr) + k;
                if (idx >= NUM_IN) idx = idx - NUM_IN;
                if (!w_grant_vld && i_in_valid[SEL_W'(idx)]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = SEL_W'(idx);
                end
            end
        end
    end

    // Only the granted slice is ever read, so X on other channels cannot leak through.
    always_comb begin
        w_data     = '0;
        o_in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant_vld && (w_grant == SEL_W'(i))) begin
                w_data        = i_in_data[i*RV_BIT_NUM +: RV_BIT_NUM];
                o_in_ready[i] = i_rst_n && w_load_en;
            end
        end
    end

    assign w_xfer     = |(o_in_ready & i_in_valid);
    assign w_ptr_next = ({1'b0, w_grant} == LAST_W) ? '0 : w_grant + SEL_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_ptr       <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            r_sel_err <= !i_mode && !w_sel_ok;
            if (w_load_en) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_data <= w_data;
                    r_out_src  <= w_grant;
                    if (i_mode) r_ptr <= w_ptr_next;
                end
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_src   = r_out_src;
    assign o_sel_err   = r_sel_err;

endmodule
